// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MUL_BUSY   = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } ctrl_state_t;

    localparam int PERF_W = 32;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating cycle and stall counters for pipe_ctrl; only present when
// PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_cycle,
    input  logic              inc_stall,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stalls
);

    localparam logic [PERF_W-1:0] ONE = 1;

    logic [PERF_W-1:0] cycles_q, cycles_d;
    logic [PERF_W-1:0] stalls_q, stalls_d;

    // Counters hold at all-ones instead of wrapping.
    always_comb begin
        cycles_d = cycles_q;
        stalls_d = stalls_q;
        if (inc_cycle && (cycles_q != '1)) begin
            cycles_d = cycles_q + ONE;
        end
        if (inc_stall && (stalls_q != '1)) begin
            stalls_d = stalls_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
            stalls_q <= '0;
        end else begin
            cycles_q <= cycles_d;
            stalls_q <= stalls_d;
        end
    end

    assign perf_cycles = cycles_q;
    assign perf_stalls = stalls_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stage enable/bubble sequencing for the 5-stage core: hazard stalls, branch
// flush, multi-cycle multiply and halt-and-drain. PIPE_CTRL_PERF_EN adds counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY  = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_inst,
    input  logic              id_hazard,
    input  logic              id_illegal,
    input  logic              id_ebreak,
    input  logic              ex_take_branch,
    input  logic              ex_is_mul,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              halted,
    output logic              halt_err,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_stalls
);

    ctrl_state_t state_q, state_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic        halt_err_q, halt_err_d;
    logic        id_stop;
    logic        mul_release;

    assign id_stop     = id_valid_inst && (id_ebreak || id_illegal);
    assign mul_release = (state_q == MUL_BUSY) && (mul_cnt_q <= 4'd1);

    always_comb begin
        state_d       = state_q;
        mul_cnt_d     = mul_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        halt_err_d    = halt_err_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        halted        = 1'b0;

        case (state_q)
            RUN, MUL_BUSY: begin
                if (mul_release) begin
                    mul_cnt_d = '0;
                    state_d   = RUN;
                end
                if ((state_q == MUL_BUSY) && !mul_release) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    mul_cnt_d     = mul_cnt_q - 4'd1;
                end else if ((state_q == RUN) && ex_take_branch) begin
                    // ID holds a wrong-path instruction; its hazard/halt flags are moot.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if ((state_q == RUN) && ex_is_mul && (MUL_LATENCY > 1)) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    mul_cnt_d     = 4'(MUL_LATENCY - 1);
                    state_d       = MUL_BUSY;
                end else if (id_stop) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    drain_cnt_d  = 3'(DRAIN_CYCLES);
                    halt_err_d   = id_illegal;
                    state_d      = HALT_DRAIN;
                end else if (id_valid_inst && id_hazard) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            HALT_DRAIN: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                drain_cnt_d  = drain_cnt_q - 3'd1;
                if (drain_cnt_q <= 3'd1) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                id_ex_bubble  = 1'b1;
                ex_mem_bubble = 1'b1;
                halted        = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            drain_cnt_q <= '0;
            halt_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            halt_err_q  <= halt_err_d;
        end
    end

    assign halt_err = halt_err_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk         (clk),
        .rst         (rst),
        .inc_cycle   (state_q != HALTED),
        .inc_stall   (!pc_en && ((state_q == RUN) || (state_q == MUL_BUSY))),
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
    );
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: cycle-indexed behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_ctrl;

    localparam int ML = 4;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid_inst = 1'b0;
    logic        id_hazard = 1'b0;
    logic        id_illegal = 1'b0;
    logic        id_ebreak = 1'b0;
    logic        ex_take_branch = 1'b0;
    logic        ex_is_mul = 1'b0;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en;
    logic        id_ex_bubble, ex_mem_bubble, halted, halt_err;
    logic [31:0] perf_cycles, perf_stalls;

    always #5 clk = ~clk;

    pipe_ctrl #(.MUL_LATENCY(ML), .DRAIN_CYCLES(DC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_inst  (id_valid_inst),
        .id_hazard      (id_hazard),
        .id_illegal     (id_illegal),
        .id_ebreak      (id_ebreak),
        .ex_take_branch (ex_take_branch),
        .ex_is_mul      (ex_is_mul),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_bubble  (ex_mem_bubble),
        .halted         (halted),
        .halt_err       (halt_err),
        .perf_cycles    (perf_cycles),
        .perf_stalls    (perf_stalls)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: remembers the cycle number at which a multiply or a halt started
    // and derives the pipeline mode from elapsed cycles.
    int   cyc, mul_start, halt_start;
    logic m_err;
    int   m_cycles, m_stalls;
    int   mode;      // 0 run, 1 mul frozen, 2 draining, 3 halted
    logic e_pc, e_ifid, e_flush, e_idex, e_idb, e_exb, e_halt;
    logic fire_mul, fire_halt;

    always_comb begin
        e_pc = 1'b1; e_ifid = 1'b1; e_flush = 1'b0; e_idex = 1'b1;
        e_idb = 1'b0; e_exb = 1'b0; e_halt = 1'b0;
        fire_mul = 1'b0; fire_halt = 1'b0; mode = 0;
        if (halt_start >= 0 && (cyc - halt_start) > DC) begin
            mode = 3;
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0;
            e_idb = 1'b1; e_exb = 1'b1; e_halt = 1'b1;
        end else if (halt_start >= 0) begin
            mode = 2;
            e_pc = 1'b0; e_ifid = 1'b0; e_idb = 1'b1;
        end else if (mul_start >= 0 && (cyc - mul_start) < ML - 1) begin
            mode = 1;
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exb = 1'b1;
        end else begin
            if (mul_start < 0 && ex_take_branch) begin
                e_flush = 1'b1; e_idb = 1'b1;
            end else if (mul_start < 0 && ex_is_mul && ML > 1) begin
                fire_mul = 1'b1;
                e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exb = 1'b1;
            end else if (id_valid_inst && (id_ebreak || id_illegal)) begin
                fire_halt = 1'b1;
                e_pc = 1'b0; e_ifid = 1'b0; e_idb = 1'b1;
            end else if (id_valid_inst && id_hazard) begin
                e_pc = 1'b0; e_ifid = 1'b0; e_idb = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= 0; mul_start <= -1; halt_start <= -1; m_err <= 1'b0;
            m_cycles <= 0; m_stalls <= 0;
        end else begin
            if (fire_mul) mul_start <= cyc;
            else if (mul_start >= 0 && (cyc - mul_start) == ML - 1) mul_start <= -1;
            if (fire_halt) begin
                halt_start <= cyc;
                m_err      <= id_illegal;
            end
            if (mode != 3) m_cycles <= m_cycles + 1;
            if (!e_pc && mode <= 1) m_stalls <= m_stalls + 1;
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        check("pc_en", {31'b0, pc_en}, {31'b0, e_pc});
        check("if_id_en", {31'b0, if_id_en}, {31'b0, e_ifid});
        check("if_id_flush", {31'b0, if_id_flush}, {31'b0, e_flush});
        check("id_ex_en", {31'b0, id_ex_en}, {31'b0, e_idex});
        check("id_ex_bubble", {31'b0, id_ex_bubble}, {31'b0, e_idb});
        check("ex_mem_bubble", {31'b0, ex_mem_bubble}, {31'b0, e_exb});
        check("halted", {31'b0, halted}, {31'b0, e_halt});
        check("halt_err", {31'b0, halt_err}, {31'b0, m_err});
`ifdef PIPE_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, m_cycles);
        check("perf_stalls", perf_stalls, m_stalls);
`else
        check("perf_cycles", perf_cycles, 32'd0);
        check("perf_stalls", perf_stalls, 32'd0);
`endif
    end

    task automatic drive(input logic v, input logic hz, input logic il,
                         input logic eb, input logic br, input logic ml);
        @(posedge clk); #1;
        id_valid_inst = v; id_hazard = hz; id_illegal = il;
        id_ebreak = eb; ex_take_branch = br; ex_is_mul = ml;
        @(negedge clk);
    endtask

    task automatic set_rst(input logic val);
        @(posedge clk); #1;
        rst = val;
        @(negedge clk);
    endtask

    int exp_stalls;

    initial begin
        @(negedge clk);
        check("lit_rst_pc_en", {31'b0, pc_en}, 32'd1);
        check("lit_rst_halted", {31'b0, halted}, 32'd0);
        set_rst(1'b1);
        $display("scenario reset released");

        drive(1, 1, 0, 0, 0, 0);
        check("lit_haz1_pc_en", {31'b0, pc_en}, 32'd0);
        check("lit_haz1_bubble", {31'b0, id_ex_bubble}, 32'd1);
        drive(1, 1, 0, 0, 0, 0);
        check("lit_haz2_if_id_en", {31'b0, if_id_en}, 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_haz_end_pc_en", {31'b0, pc_en}, 32'd1);
`ifdef PIPE_CTRL_PERF_EN
        exp_stalls = 2;
`else
        exp_stalls = 0;
`endif
        check("lit_haz_perf_stalls", perf_stalls, exp_stalls);
        $display("scenario hazard x2 stalls=%0d", perf_stalls);

        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (i < 3) begin
                check("lit_mul_frozen_pc", {31'b0, pc_en}, 32'd0);
                check("lit_mul_frozen_exb", {31'b0, ex_mem_bubble}, 32'd1);
            end else begin
                check("lit_mul_release_exb", {31'b0, ex_mem_bubble}, 32'd0);
                check("lit_mul_release_pc", {31'b0, pc_en}, 32'd1);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        check("lit_mul_after_pc", {31'b0, pc_en}, 32'd1);
        $display("scenario multiply latency %0d", ML);

        drive(1, 1, 0, 1, 1, 0);
        check("lit_br_flush", {31'b0, if_id_flush}, 32'd1);
        check("lit_br_bubble", {31'b0, id_ex_bubble}, 32'd1);
        check("lit_br_pc_en", {31'b0, pc_en}, 32'd1);
        check("lit_br_if_id_en", {31'b0, if_id_en}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        check("lit_br_no_halt_pc", {31'b0, pc_en}, 32'd1);
        $display("scenario branch beats hazard and ebreak");

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            check("lit_inv_illegal_pc", {31'b0, pc_en}, 32'd1);
        end
        $display("scenario invalid illegal ignored");

        drive(1, 0, 1, 0, 0, 0);
        check("lit_ill_detect_pc", {31'b0, pc_en}, 32'd0);
        for (int k = 1; k <= 24; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (k < 4) check("lit_ill_not_yet_halted", {31'b0, halted}, 32'd0);
            if (k == 4) check("lit_ill_halted", {31'b0, halted}, 32'd1);
            if (k == 1 || k == 24) check("lit_ill_halt_err", {31'b0, halt_err}, 32'd1);
            if (k >= 4) check("lit_ill_enables", {29'b0, pc_en, if_id_en, id_ex_en}, 32'd0);
        end
        $display("scenario illegal halt");

        set_rst(1'b0);
        check("lit_rst2_halted", {31'b0, halted}, 32'd0);
        check("lit_rst2_halt_err", {31'b0, halt_err}, 32'd0);
        set_rst(1'b1);

        drive(1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (k == 3) check("lit_eb_not_yet_halted", {31'b0, halted}, 32'd0);
            if (k == 4) check("lit_eb_halted", {31'b0, halted}, 32'd1);
            if (k == 5) check("lit_eb_halt_err", {31'b0, halt_err}, 32'd0);
        end
        $display("scenario ebreak halt");
        set_rst(1'b0);
        set_rst(1'b1);

        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 0, 1);
            if (i < 3) begin
                check("lit_mulbrk_idb", {31'b0, id_ex_bubble}, 32'd0);
                check("lit_mulbrk_exb", {31'b0, ex_mem_bubble}, 32'd1);
            end else begin
                check("lit_mulbrk_rel_exb", {31'b0, ex_mem_bubble}, 32'd0);
                check("lit_mulbrk_rel_idb", {31'b0, id_ex_bubble}, 32'd1);
                check("lit_mulbrk_rel_pc", {31'b0, pc_en}, 32'd0);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        set_rst(1'b0);
        check("lit_drain_rst_pc", {31'b0, pc_en}, 32'd1);
        check("lit_drain_rst_idb", {31'b0, id_ex_bubble}, 32'd0);
        set_rst(1'b1);
        drive(0, 0, 0, 0, 0, 0);
        check("lit_drain_after_pc", {31'b0, pc_en}, 32'd1);
        check("lit_drain_after_halted", {31'b0, halted}, 32'd0);
        $display("scenario mul+ebreak then reset mid-drain");

        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        ex_is_mul = 1'b0;
        @(negedge clk);
        check("lit_mulrst_pc", {31'b0, pc_en}, 32'd1);
        check("lit_mulrst_exb", {31'b0, ex_mem_bubble}, 32'd0);
        set_rst(1'b1);
        check("lit_mulrst_cycles", perf_cycles, 32'd0);
        check("lit_mulrst_stalls", perf_stalls, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        check("lit_mulrst_after_pc", {31'b0, pc_en}, 32'd1);
        $display("scenario reset mid-multiply");

        drive(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage in-order core. Consumes the decode-stage hazard, illegal-instruction and ebreak indications together with the EX-stage branch and multiply status. Produces the per-stage enable and bubble/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. Owns multi-cycle multiply stalls and the ebreak/illegal halt-and-drain sequence.

## Interface
- MUL_LATENCY, 4: EX cycles a MUL/MULHU occupies; legal 1..16.
- DRAIN_CYCLES, 3: cycles allowed for older instructions to retire (EX, MEM, WB) before halting; legal 1..7.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- id_valid_inst  in  1  IF/ID holds a valid instruction.
- id_hazard  in  1  decode RAW hazard against ID/EX, EX/MEM or MEM/WB destination.
- id_illegal  in  1  decoder flags the IF/ID instruction illegal.
- id_ebreak  in  1  IF/ID instruction is ebreak.
- ex_take_branch  in  1  EX resolved a taken conditional or unconditional branch.
- ex_is_mul  in  1  EX holds a valid MUL/MULHU.
- pc_en  out  1  PC register loads the next PC.
- if_id_en  out  1  IF/ID register loads.
- if_id_flush  out  1  IF/ID loads a noop (invalid).
- id_ex_en  out  1  ID/EX register loads.
- id_ex_bubble  out  1  ID/EX loads a noop.
- ex_mem_bubble  out  1  EX/MEM loads a noop.
- halted  out  1  pipeline stopped; sticky until reset.
- halt_err  out  1  halt was caused by an illegal instruction; sticky.
- perf_cycles  out  32  cycle counter.
- perf_stalls  out  32  stall-cycle counter.

## Operation
- States: RUN, MUL_BUSY, HALT_DRAIN, HALTED.
- Control outputs are combinational from registered state, counter and current inputs. State, counters and sticky flags are registered.
- RUN priority, highest first. Defaults: all enables 1, all bubbles and flushes 0.
  1. ex_take_branch: if_id_flush=1, id_ex_bubble=1, pc_en=1. Overrides all ID conditions, which are wrong-path.
  2. ex_is_mul with MUL_LATENCY>1: pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1. Load mul_cnt=MUL_LATENCY-1; go to MUL_BUSY.
  3. id_valid_inst and (id_ebreak or id_illegal): pc_en=if_id_en=0, id_ex_bubble=1. Load drain_cnt=DRAIN_CYCLES; set halt_err=id_illegal; go to HALT_DRAIN.
  4. id_valid_inst and id_hazard: pc_en=if_id_en=0, id_ex_bubble=1.
- MUL_BUSY with mul_cnt>1: front frozen as in rule 2; decrement mul_cnt.
- MUL_BUSY with mul_cnt==1 (release cycle): ex_mem_bubble=0. Rules 3 and 4 apply, rule 2 is suppressed. Go to RUN.
- HALT_DRAIN: pc_en=if_id_en=0, id_ex_bubble=1; decrement drain_cnt. At drain_cnt==1, go to HALTED.
- HALTED: all enables 0, id_ex_bubble=ex_mem_bubble=1, halted=1. Exit only by reset.
- MUL_LATENCY==1: rule 2 is never taken.

## Timing
- Async reset: state=RUN, mul_cnt=drain_cnt=0, halted=0, halt_err=0, perf counters 0.
- Outputs during reset follow RUN with current inputs.
- Stall and flush response is same-cycle (zero latency) relative to the inputs.
- Multiply costs exactly MUL_LATENCY-1 extra cycles. The EX/MEM register captures the product on the release cycle.
- halted rises exactly DRAIN_CYCLES+1 cycles after the cycle in which rule 3 fired.
- Simultaneous taken branch and ebreak in ID: branch wins, no halt.
- Simultaneous MUL in EX and ebreak in ID: multiply completes first; ebreak is re-evaluated on the release cycle.
- Reset mid-MUL_BUSY or mid-HALT_DRAIN: return to RUN immediately, with no residual stall.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_cycles increments every cycle not in HALTED.
  - perf_stalls increments on cycles with pc_en==0 in RUN or MUL_BUSY.
  - Both counters saturate at 32'hFFFF_FFFF.
- PIPE_CTRL_PERF_EN undefined: perf_cycles and perf_stalls are tied to 0 and no counter flops exist.

## Structure
- Package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {RUN, MUL_BUSY, HALT_DRAIN, HALTED};
  - constant PERF_W=32.
- One sub-module, pipe_ctrl_perf, holds the two saturating counters. It is instantiated only under PIPE_CTRL_PERF_EN.

## Test plan
- Hazard held for 2 cycles in RUN: pc_en=if_id_en=0 and id_ex_bubble=1 for exactly those 2 cycles; perf_stalls=2.
- ex_is_mul with MUL_LATENCY=4: front frozen and ex_mem_bubble=1 for 3 cycles; 4th cycle ex_mem_bubble=0; state returns to RUN.
- Taken branch together with id_hazard and id_ebreak: if_id_flush=id_ex_bubble=pc_en=1; no halt; no hazard stall.
- Valid ebreak with DRAIN_CYCLES=3: halted=1 on cycle 4 after detection; halt_err=0; enables stay 0 for 20 further cycles.
- Valid illegal instruction: same sequence as ebreak with halt_err=1. Invalid illegal (id_valid_inst=0) is ignored.
- rst low during MUL_BUSY cycle 2: outputs return to RUN defaults; perf counters read 0 after rst rises.
